// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and default widths for mem_req_ctrl, the initiator-side
// controller for the synchronous single-port Mem RAM.
//   mem_ctrl_state_t : controller FSM state encoding
//   MEM_*_WIDTH      : default address / data / burst-length widths
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 5;
    localparam int MEM_DATA_WIDTH = 4;
    localparam int MEM_LEN_WIDTH  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } mem_ctrl_state_t;

endpackage

// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
// Converts a valid/ready request channel into timed port activity on the
// synchronous single-port Mem RAM and returns read data on a valid/ready
// response channel, absorbing the RAM's one-cycle registered read latency.
//
// Optional feature: define MEM_BURST_EN to add i_req_len and incrementing,
// wrapping read bursts of i_req_len + 1 beats. Without it every read is a
// single beat and o_rsp_last is high whenever o_rsp_valid is high.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   i_req_valid     : request present          o_req_ready : request accepted
//   i_req_we        : 1 = write, 0 = read       i_req_addr  : start address
//   i_req_wdata     : write data                i_req_len   : beats - 1 (burst)
//   o_rsp_valid     : read data available       i_rsp_ready : client takes data
//   o_rsp_rdata     : read data                 o_rsp_last  : final beat
//   o_mem_we / o_mem_addr / o_mem_data_in : to Mem
//   i_mem_data_out  : from Mem, valid the cycle after the address
// ---------------------------------------------------------------------------
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
`ifdef MEM_BURST_EN
    parameter int LEN_WIDTH  = MEM_LEN_WIDTH,
`endif
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
`ifdef MEM_BURST_EN
    input  logic [LEN_WIDTH-1:0]  i_req_len,
`endif
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_last,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data_in,
    input  logic [DATA_WIDTH-1:0] i_mem_data_out
);

    mem_ctrl_state_t       r_state;
    mem_ctrl_state_t       w_state_next;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_more;
    logic                  w_we_next;
    logic                  w_last_next;

    logic                  r_we_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_wdata_q;
    logic [DATA_WIDTH-1:0] r_rdata_q;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_last;
    logic                  r_mem_we;

`ifdef MEM_BURST_EN
    logic [LEN_WIDTH-1:0]  r_beats_left;
    logic [LEN_WIDTH-1:0]  w_beats_next;

    // Beat counter: loaded on accept (writes never burst), stepped per beat.
    always_comb begin
        w_beats_next = r_beats_left;
        if (w_accept) begin
            w_beats_next = i_req_we ? {LEN_WIDTH{1'b0}} : i_req_len;
        end else if (w_advance) begin
            w_beats_next = r_beats_left - LEN_WIDTH'(1);
        end else begin
            w_beats_next = r_beats_left;
        end
    end

    assign w_more      = (r_beats_left != {LEN_WIDTH{1'b0}});
    assign w_last_next = (w_beats_next == {LEN_WIDTH{1'b0}});

    // Beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats_left <= {LEN_WIDTH{1'b0}};
        end else begin
            r_beats_left <= w_beats_next;
        end
    end
`else
    assign w_more      = 1'b0;
    assign w_last_next = 1'b1;
`endif

    // Next-state logic; w_accept / w_advance qualify the datapath updates.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = CMD;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CMD: begin
                if (r_we_q) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (i_rsp_ready && w_more) begin
                    w_advance    = 1'b1;
                    w_state_next = CMD;
                end else if (i_rsp_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = RESP;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Command direction for the upcoming CMD cycle (burst beats keep r_we_q = 0).
    assign w_we_next = w_accept ? i_req_we : r_we_q;

    // State register and registered handshake / strobe outputs, decoded from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == IDLE);
            r_rsp_valid <= (w_state_next == RESP);
            r_rsp_last  <= (w_state_next == RESP) && w_last_next;
            r_mem_we    <= (w_state_next == CMD) && w_we_next;
        end
    end

    // Request capture, burst address increment (wraps naturally) and read capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_q    <= 1'b0;
            r_addr_q  <= {ADDR_WIDTH{1'b0}};
            r_wdata_q <= {DATA_WIDTH{1'b0}};
            r_rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            if (w_accept) begin
                r_we_q    <= i_req_we;
                r_addr_q  <= i_req_addr;
                r_wdata_q <= i_req_wdata;
            end else if (w_advance) begin
                r_addr_q  <= r_addr_q + ADDR_WIDTH'(1);
            end
            if (r_state == WAIT) begin
                r_rdata_q <= i_mem_data_out;
            end
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rdata_q;
    assign o_rsp_last    = r_rsp_last;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_addr_q;
    assign o_mem_data_in = r_wdata_q;

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Initiator-side controller that drives the synchronous single-port `Mem` RAM on behalf of a client such as instruction fetch, the data path or a loader. It converts a valid/ready request channel into correctly timed RAM port activity (`we`, `addr`, `data_in`). It absorbs the RAM's one-cycle registered read latency and returns read data on a valid/ready response channel. It sits between the CPU core and the `Mem` instance; `Mem` is instantiated alongside it, not inside it.

## Interface
- `ADDR_WIDTH`, 5, RAM address width; must match the `Mem` instance.
- `DATA_WIDTH`, 4, RAM word width.
- `LEN_WIDTH`, 2, burst length field width (beats = `req_len` + 1); used only with `MEM_BURST_EN`.

Clocking and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  single clock, rising edge; also clocks `Mem`.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  controller accepts a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  start address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_len`  in  LEN_WIDTH  read burst length minus 1; present only with `MEM_BURST_EN`.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  client takes the read data.
- `rsp_rdata`  out  DATA_WIDTH  read data.
- `rsp_last`  out  1  final beat of the read.
- `mem_we`  out  1  to `Mem.we`.
- `mem_addr`  out  ADDR_WIDTH  to `Mem.addr`.
- `mem_data_in`  out  DATA_WIDTH  to `Mem.data_in`.
- `mem_data_out`  in  DATA_WIDTH  from `Mem.data_out`; registered and valid the cycle after the address is presented.

## Operation
- FSM states: IDLE, CMD, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`: latch we, addr, wdata and len into `*_q` registers, then go to CMD.
- CMD: lasts exactly one cycle.
  - `mem_addr` = `addr_q`; `mem_we` = `we_q`; `mem_data_in` = `wdata_q`.
  - Write: go to IDLE. No response is produced for writes.
  - Read: go to WAIT.
- WAIT: capture `mem_data_out` into `rdata_q`, then go to RESP.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_rdata` = `rdata_q`.
  - `rsp_last` = (`beats_left` == 0).
  - On `rsp_ready`: if `beats_left` > 0, set `addr_q` = `addr_q` + 1 modulo 2^ADDR_WIDTH, decrement `beats_left`, and go to CMD. Otherwise go to IDLE.
- `req_ready` = 0 in every state other than IDLE. No request is accepted in the cycle RESP completes.
- `mem_we` = 0 in every state other than CMD. `mem_addr` and `mem_data_in` always reflect `addr_q` and `wdata_q`.
- Write bursts are not supported: `req_len` is ignored when `req_we` = 1.

## Timing
- Reset values (all take effect immediately on `rst_n` low):
  - state = IDLE.
  - `req_ready` = 1.
  - `rsp_valid` = 0, `rsp_last` = 0, `rsp_rdata` = 0.
  - `mem_we` = 0, `mem_addr` = 0, `mem_data_in` = 0.
  - All `*_q` registers = 0.
- Read latency: handshake in cycle 0 → address on the RAM in cycle 1 → RAM data in cycle 2 → `rsp_valid` in cycle 3. Every later beat takes 3 cycles from the previous beat's `rsp_ready`.
- Write: handshake in cycle 0 → `mem_we` = 1 in cycle 1 → `req_ready` = 1 again in cycle 2. Peak throughput is one write per 2 cycles.
- Read after write to the same address returns the new data, because the read CMD always follows the write CMD by at least one cycle.
- `rsp_valid`, `rsp_rdata` and `rsp_last` hold stable while `rsp_ready` = 0. Backpressure is unbounded.
- Burst addresses wrap at the top of the address space; for example, 31 is followed by 0.
- Reset mid-operation:
  - Any in-flight beat or burst is discarded.
  - `mem_we` drops asynchronously, so a partially issued write is not guaranteed.
  - No response follows reset release.

## Configuration
- `MEM_BURST_EN` defined:
  - `req_len` port and `beats_left` counter are present.
  - Reads return `req_len` + 1 beats at incrementing addresses.
  - `rsp_last` is asserted on the final beat only.
- `MEM_BURST_EN` undefined:
  - No `req_len` port and no counter.
  - Every read is a single beat and `rsp_last` = 1 whenever `rsp_valid` = 1.

## Structure
- Package `mem_ctrl_pkg`:
  - `typedef enum logic [1:0]` `mem_ctrl_state_t` with values {IDLE, CMD, WAIT, RESP}.
  - Default width constants for address, data and length.
- No sub-module: a single FSM plus datapath registers. Beat counting remains inline under `MEM_BURST_EN`.
- The bench connects `mem_req_ctrl` to a `Mem` instance with matching parameters.

## Test plan
1. Reset: hold `rst_n` low for 3 cycles, then release. Expect `req_ready` = 1, `rsp_valid` = 0 and `mem_we` = 0 throughout.
2. Write 0xA to address 5, then read address 5:
   - `mem_we` is high for exactly one cycle with `mem_addr` = 5.
   - `rsp_valid` rises 3 cycles after the read handshake with `rsp_rdata` = 0xA and `rsp_last` = 1.
3. Backpressure: read address 5 with `rsp_ready` low for 4 cycles. Expect `rsp_valid` and `rsp_rdata` = 0xA held, `req_ready` = 0, and IDLE reached the cycle after `rsp_ready`.
4. Wrapping burst (`MEM_BURST_EN`):
   - Write 1, 2, 3 and 4 to addresses 30, 31, 0 and 1.
   - Read address 30 with `req_len` = 3.
   - Expect beats 1, 2, 3, 4 with `mem_addr` sequence 30, 31, 0, 1, and `rsp_last` asserted only on beat 4.
5. Reset mid-burst: pull `rst_n` low while in RESP on beat 2. Expect `rsp_valid` = 0 immediately, `req_ready` = 1 after release, and no further beats.
6. Back-to-back writes: hold `req_valid` high with 4 writes to addresses 0–3. Expect one write accepted every 2 cycles, and readback returns the written values.
